// File: rtl/jtag_pkg.sv
// Shared JTAG constants: default IR geometry, well-known opcodes and the
// opcode legality lookup used by the instruction register.
package jtag_pkg;

  localparam int unsigned IR_LEN     = 4;
  localparam int unsigned IR_LEN_MAX = 8;
  localparam int unsigned MASK_W     = 2 ** IR_LEN_MAX;

  localparam logic [IR_LEN-1:0] IDCODE_INST = 4'h1;
  localparam logic [IR_LEN-1:0] BYPASS_INST = '1;

  // Mask and opcode are zero-extended to the widest supported IR so one
  // function serves every IR_LEN instantiation.
  function automatic logic ir_legal(input logic [MASK_W-1:0]     mask,
                                    input logic [IR_LEN_MAX-1:0] opcode);
    return mask[opcode];
  endfunction

endpackage

// File: rtl/jtag_ir_ext.sv
// JTAG instruction register with capture status, legality/length checking
// and a change strobe. Optional macro JTAG_IR_PRIV_LOCK_EN adds priv_unlock.
module jtag_ir_ext
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_LEN      = jtag_pkg::IR_LEN,
  parameter logic [IR_LEN-1:0]    RESET_INST  = IR_LEN'(jtag_pkg::IDCODE_INST),
  parameter logic [IR_LEN-1:0]    BYPASS_INST = '1,
  parameter logic [2**IR_LEN-1:0] LEGAL_MASK  = '1
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tdi,
  input  logic              reset,
  input  logic              capir,
  input  logic              shiftir,
  input  logic              updateir,
  input  logic [IR_LEN-3:0] status_in,
`ifdef JTAG_IR_PRIV_LOCK_EN
  input  logic              priv_unlock,
`endif
  output logic              tdo,
  output logic              tdo_en,
  output logic [IR_LEN-1:0] curr_inst,
  output logic              inst_changed,
  output logic              shift_err
);

  localparam int unsigned      CNT_W    = $clog2(IR_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IR_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IR_LEN + 1);

  logic [IR_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IR_LEN-1:0] curr_q, curr_d;
  logic              chg_q, chg_d;
  logic              err_q, err_d;
  logic              tdo_q, tdo_d;
  logic              en_q, en_d;
  logic              op_legal;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (capir) begin
      shreg_d = {status_in, 2'b01};
      cnt_d   = '0;
    end else if (shiftir) begin
      shreg_d = {tdi, shreg_q[IR_LEN-1:1]};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    op_legal = ir_legal(MASK_W'(LEGAL_MASK), IR_LEN_MAX'(shreg_q));
`ifdef JTAG_IR_PRIV_LOCK_EN
    // MSB-set opcodes are private and need an explicit unlock.
    op_legal = op_legal && (priv_unlock || !shreg_q[IR_LEN-1]);
`endif
  end

  always_comb begin
    curr_d = curr_q;
    err_d  = err_q;
    tdo_d  = tdo_q;
    en_d   = 1'b0;
    if (reset) begin
      curr_d = RESET_INST;
      err_d  = 1'b0;
    end else if (updateir) begin
      if (cnt_q == CNT_FULL) begin
        curr_d = op_legal ? shreg_q : BYPASS_INST;
      end else begin
        curr_d = BYPASS_INST;
        err_d  = 1'b1;
      end
    end
    if (shiftir) begin
      tdo_d = shreg_q[0];
      en_d  = 1'b1;
    end
    chg_d = (curr_d != curr_q);
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      curr_q <= RESET_INST;
      chg_q  <= 1'b0;
      err_q  <= 1'b0;
      tdo_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      curr_q <= curr_d;
      chg_q  <= chg_d;
      err_q  <= err_d;
      tdo_q  <= tdo_d;
      en_q   <= en_d;
    end
  end

  assign tdo          = tdo_q;
  assign tdo_en       = en_q;
  assign curr_inst    = curr_q;
  assign inst_changed = chg_q;
  assign shift_err    = err_q;

endmodule

// File: tb/tb_jtag_ir_ext.sv
// Directed bench for jtag_ir_ext: per-cycle vector table plus hand sequences
// for mask, trst-mid-shift and (when JTAG_IR_PRIV_LOCK_EN) private opcodes.
module tb_jtag_ir_ext;

  logic       tck = 1'b0;
  logic       trst = 1'b0;
  logic       tdi = 1'b0, reset = 1'b0, capir = 1'b0, shiftir = 1'b0, updateir = 1'b0;
  logic [1:0] status_in = 2'b00;
  logic       priv_unlock = 1'b0;

  logic       tdo_a, en_a, chg_a, err_a;
  logic [3:0] curr_a;
  logic       tdo_b, en_b, chg_b, err_b;
  logic [3:0] curr_b;

  logic       s_tdo, s_en, s_chg, s_err, sb_chg, sb_err;
  logic [3:0] s_curr, sb_curr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tck = ~tck;

  jtag_ir_ext u_dut (
    .tck(tck), .trst(trst), .tdi(tdi), .reset(reset), .capir(capir),
    .shiftir(shiftir), .updateir(updateir), .status_in(status_in),
`ifdef JTAG_IR_PRIV_LOCK_EN
    .priv_unlock(priv_unlock),
`endif
    .tdo(tdo_a), .tdo_en(en_a), .curr_inst(curr_a),
    .inst_changed(chg_a), .shift_err(err_a)
  );

  jtag_ir_ext #(.LEGAL_MASK(16'hFFDF)) u_dut_mask (
    .tck(tck), .trst(trst), .tdi(tdi), .reset(reset), .capir(capir),
    .shiftir(shiftir), .updateir(updateir), .status_in(status_in),
`ifdef JTAG_IR_PRIV_LOCK_EN
    .priv_unlock(priv_unlock),
`endif
    .tdo(tdo_b), .tdo_en(en_b), .curr_inst(curr_b),
    .inst_changed(chg_b), .shift_err(err_b)
  );

  typedef struct {
    logic       cap, sh, up, rst, din;
    logic [1:0] st;
    logic       tdo, en;
    logic [3:0] curr;
    logic       chg, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cap, sh, up, rst, din, input logic [1:0] st,
                              input logic e_tdo, e_en, input logic [3:0] e_curr,
                              input logic e_chg, e_err);
    vec_t v;
    v.cap = cap; v.sh = sh; v.up = up; v.rst = rst; v.din = din; v.st = st;
    v.tdo = e_tdo; v.en = e_en; v.curr = e_curr; v.chg = e_chg; v.err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One tck cycle starting just after a posedge; outputs are snapshotted
  // 1 time unit after the intervening negedge.
  task automatic step(input logic cap, sh, up, rst, din, input logic [1:0] st);
    capir = cap; shiftir = sh; updateir = up; reset = rst; tdi = din; status_in = st;
    @(negedge tck); #1;
    s_tdo = tdo_a; s_en = en_a; s_curr = curr_a; s_chg = chg_a; s_err = err_a;
    sb_curr = curr_b; sb_chg = chg_b; sb_err = err_b;
    @(posedge tck); #1;
  endtask

  task automatic load(input logic [3:0] op);
    step(1, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, op[i], 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //           cap sh up rst tdi st    tdo en curr  chg err
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b10, 0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 1, 0, 4'h0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 4'h2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 1, 1, 4'h2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 4'hF, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'hF, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'hF, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'hF, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'hF, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 4'h2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 4'h1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 1, 0, 4'hF, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 1, 0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 1, 0, 4'h1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'b11, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 2'b00, 1, 0, 4'h0, 1, 0));

    trst = 1'b1;
    #12;
    chk("rst_curr", 0, 8'(curr_a), 8'h1);
    chk("rst_tdo",  0, 8'(tdo_a),  8'h0);
    chk("rst_en",   0, 8'(en_a),   8'h0);
    chk("rst_chg",  0, 8'(chg_a),  8'h0);
    chk("rst_err",  0, 8'(err_a),  8'h0);
    trst = 1'b0;
    @(posedge tck); #1;

    foreach (vecs[i]) begin
      step(vecs[i].cap, vecs[i].sh, vecs[i].up, vecs[i].rst, vecs[i].din, vecs[i].st);
      chk("tdo",  i, 8'(s_tdo),  8'(vecs[i].tdo));
      chk("en",   i, 8'(s_en),   8'(vecs[i].en));
      chk("curr", i, 8'(s_curr), 8'(vecs[i].curr));
      chk("chg",  i, 8'(s_chg),  8'(vecs[i].chg));
      chk("err",  i, 8'(s_err),  8'(vecs[i].err));
    end

    // Opcode 5 is masked off in the second instance only.
    load(4'h5);
    step(0, 0, 1, 0, 0, 2'b00);
    chk("mask_a_curr", 0, 8'(s_curr),  8'h5);
    chk("mask_b_curr", 0, 8'(sb_curr), 8'hF);
    chk("mask_b_err",  0, 8'(sb_err),  8'h0);
    chk("mask_b_chg",  0, 8'(sb_chg),  8'h1);
    load(4'hF);
    step(0, 0, 1, 0, 0, 2'b00);
    chk("mask_a_curr", 1, 8'(s_curr),  8'hF);
    chk("mask_a_chg",  1, 8'(s_chg),   8'h1);
    chk("mask_b_curr", 1, 8'(sb_curr), 8'hF);
    chk("mask_b_chg",  1, 8'(sb_chg),  8'h0);
    chk("mask_b_err",  1, 8'(sb_err),  8'h0);

    // trst in the middle of a shift abandons it.
    step(1, 0, 0, 0, 0, 2'b11);
    step(0, 1, 0, 0, 1, 2'b00);
    step(0, 1, 0, 0, 1, 2'b00);
    capir = 0; shiftir = 0; updateir = 0; reset = 0; tdi = 0;
    #2 trst = 1'b1;
    #1;
    chk("trst_mid_curr", 0, 8'(curr_a), 8'h1);
    chk("trst_mid_tdo",  0, 8'(tdo_a),  8'h0);
    chk("trst_mid_err",  0, 8'(err_a),  8'h0);
    trst = 1'b0;
    @(posedge tck); #1;
    step(0, 0, 1, 0, 0, 2'b00);
    chk("trst_upd_curr", 0, 8'(s_curr), 8'hF);
    chk("trst_upd_err",  0, 8'(s_err),  8'h1);
    chk("trst_upd_chg",  0, 8'(s_chg),  8'h1);

`ifdef JTAG_IR_PRIV_LOCK_EN
    priv_unlock = 1'b0;
    load(4'h9);
    step(0, 0, 1, 0, 0, 2'b00);
    chk("priv_locked", 0, 8'(s_curr), 8'hF);
    priv_unlock = 1'b1;
    load(4'h9);
    step(0, 0, 1, 0, 0, 2'b00);
    chk("priv_unlocked", 0, 8'(s_curr), 8'h9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
